// File: rtl/ipv4_tx_framer.sv
// IPv4 header framer for the 100M MII transmit path: sequential header checksum, then
// 20 header bytes and the payload streamed as nibbles. Define IPV4_TX_DF_EN to set Don't Fragment.
module ipv4_tx_framer #(
    parameter logic [31:0] SRC_IP  = 32'hC0A8_8958,
    parameter logic [7:0]  TTL     = 8'd64,
    parameter int          LEN_W   = 11,
    parameter logic [15:0] ID_INIT = 16'h0000
) (
    input  logic             mii_tx_clk,
    input  logic             rst_n,
    input  logic             tx_go,
    input  logic [31:0]      dst_ip,
    input  logic [7:0]       protocol,
    input  logic [LEN_W-1:0] payload_len,
    output logic             busy,
    output logic             len_err,
    output logic             mac_go,
    output logic [15:0]      mac_len,
    input  logic             mac_rq,
    output logic [3:0]       mac_data,
    output logic             fifo_rq,
    input  logic [3:0]       fifo_da,
    output logic             tx_done
);

`ifdef IPV4_TX_DF_EN
    localparam logic [15:0] FLAGS = 16'h4000;
`else
    localparam logic [15:0] FLAGS = 16'h0000;
`endif

    localparam int NIB_W = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_LAUNCH,
        S_WAIT,
        S_HDR,
        S_PAYLOAD
    } state_t;

    state_t            state_reg;
    logic [31:0]       dst_reg;
    logic [7:0]        proto_reg;
    logic [15:0]       id_reg;
    logic [19:0]       acc_reg;
    logic [15:0]       csum_reg;
    logic [3:0]        calc_cnt_reg;
    logic [NIB_W-1:0]  nib_reg;
    logic [NIB_W-1:0]  last_reg;

    logic              len_ok;
    logic [15:0]       calc_word;
    logic [19:0]       fold1;
    logic [19:0]       fold2;
    logic [15:0]       csum_next;
    logic [159:0]      hdr_vec;
    logic [7:0]        hdr_bytes [20];
    logic [7:0]        hdr_byte;
    logic [3:0]        hdr_nib;

    assign len_ok = (payload_len != '0) && (32'(payload_len) <= 32'd1480);

    always_comb begin
        calc_word = 16'h0000;
        case (calc_cnt_reg)
            4'd0:    calc_word = 16'h4500;
            4'd1:    calc_word = mac_len;
            4'd2:    calc_word = id_reg;
            4'd3:    calc_word = FLAGS;
            4'd4:    calc_word = {TTL, proto_reg};
            4'd5:    calc_word = SRC_IP[31:16];
            4'd6:    calc_word = SRC_IP[15:0];
            4'd7:    calc_word = dst_reg[31:16];
            4'd8:    calc_word = dst_reg[15:0];
            default: calc_word = 16'h0000;
        endcase
    end

    // Two end-around folds are enough: nine 16-bit words never overflow 20 bits.
    assign fold1     = {4'h0, acc_reg[15:0]} + {16'h0000, acc_reg[19:16]};
    assign fold2     = {4'h0, fold1[15:0]} + {16'h0000, fold1[19:16]};
    assign csum_next = ~fold2[15:0];

    assign hdr_vec = {8'h45, 8'h00, mac_len, id_reg, FLAGS, TTL, proto_reg,
                      csum_reg, SRC_IP, dst_reg};

    generate
        for (genvar gi = 0; gi < 20; gi++) begin : g_hdr_byte
            assign hdr_bytes[gi] = hdr_vec[159-8*gi -: 8];
        end
    endgenerate

    // Network byte order, low nibble of each byte first.
    assign hdr_byte = hdr_bytes[nib_reg[5:1]];
    assign hdr_nib  = nib_reg[0] ? hdr_byte[7:4] : hdr_byte[3:0];

    assign fifo_rq = (state_reg == S_PAYLOAD) && mac_rq;

    always_ff @(posedge mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            dst_reg      <= '0;
            proto_reg    <= '0;
            id_reg       <= ID_INIT;
            acc_reg      <= '0;
            csum_reg     <= '0;
            calc_cnt_reg <= '0;
            nib_reg      <= '0;
            last_reg     <= '0;
            busy         <= 1'b0;
            len_err      <= 1'b0;
            mac_go       <= 1'b0;
            mac_len      <= '0;
            mac_data     <= '0;
            tx_done      <= 1'b0;
        end else begin
            len_err <= 1'b0;
            mac_go  <= 1'b0;
            tx_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    mac_data <= '0;
                    if (tx_go) begin
                        if (len_ok) begin
                            dst_reg      <= dst_ip;
                            proto_reg    <= protocol;
                            mac_len      <= 16'(payload_len) + 16'd20;
                            last_reg     <= NIB_W'({payload_len, 1'b0}) + NIB_W'(39);
                            acc_reg      <= '0;
                            calc_cnt_reg <= '0;
                            busy         <= 1'b1;
                            state_reg    <= S_CALC;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (calc_cnt_reg == 4'd9) begin
                        csum_reg  <= csum_next;
                        mac_go    <= 1'b1;
                        state_reg <= S_LAUNCH;
                    end else begin
                        acc_reg      <= acc_reg + {4'h0, calc_word};
                        calc_cnt_reg <= calc_cnt_reg + 4'd1;
                    end
                end
                S_LAUNCH: begin
                    nib_reg   <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (mac_rq) begin
                        mac_data  <= hdr_nib;
                        nib_reg   <= NIB_W'(1);
                        state_reg <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (mac_rq) begin
                        mac_data <= hdr_nib;
                        nib_reg  <= nib_reg + NIB_W'(1);
                        if (nib_reg == NIB_W'(39)) begin
                            state_reg <= S_PAYLOAD;
                        end
                    end else begin
                        mac_data  <= '0;
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    if (mac_rq) begin
                        mac_data <= fifo_da;
                        nib_reg  <= nib_reg + NIB_W'(1);
                        if (nib_reg == last_reg) begin
                            tx_done   <= 1'b1;
                            id_reg    <= id_reg + 16'd1;
                            busy      <= 1'b0;
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        // Aborted packet: the FIFO is left as is, id is not consumed.
                        mac_data  <= '0;
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipv4_tx_framer.sv
// Randomized self-checking bench for ipv4_tx_framer against a byte-level header model.
// A second instance with ID_INIT=FFFF covers the identification wrap.
module tb_ipv4_tx_framer;

    localparam logic [31:0] SRC   = 32'hC0A8_8958;
    localparam logic [7:0]  TTL_V = 8'd64;
`ifdef IPV4_TX_DF_EN
    localparam logic [15:0] FLAGS_EXP = 16'h4000;
    localparam logic [15:0] NOM_CSUM  = 16'hA726;
    localparam logic [15:0] NOM_FLNIB = 16'h0040;
`else
    localparam logic [15:0] FLAGS_EXP = 16'h0000;
    localparam logic [15:0] NOM_CSUM  = 16'hE726;
    localparam logic [15:0] NOM_FLNIB = 16'h0000;
`endif

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst_n, tx_go, mac_rq, sel;
    logic [31:0] dst_ip;
    logic [7:0]  protocol;
    logic [10:0] payload_len;
    logic [3:0]  fifo_da;

    logic        busy_a, len_err_a, mac_go_a, fifo_rq_a, tx_done_a;
    logic [15:0] mac_len_a;
    logic [3:0]  mac_data_a;
    logic        busy_b, len_err_b, mac_go_b, fifo_rq_b, tx_done_b;
    logic [15:0] mac_len_b;
    logic [3:0]  mac_data_b;

    logic        busy, len_err, mac_go, fifo_rq, tx_done;
    logic [15:0] mac_len;
    logic [3:0]  mac_data;

    ipv4_tx_framer dut_a (
        .mii_tx_clk(clk), .rst_n(rst_n), .tx_go(tx_go && !sel), .dst_ip(dst_ip),
        .protocol(protocol), .payload_len(payload_len), .busy(busy_a), .len_err(len_err_a),
        .mac_go(mac_go_a), .mac_len(mac_len_a), .mac_rq(mac_rq && !sel), .mac_data(mac_data_a),
        .fifo_rq(fifo_rq_a), .fifo_da(fifo_da), .tx_done(tx_done_a)
    );

    ipv4_tx_framer #(.ID_INIT(16'hFFFF)) dut_b (
        .mii_tx_clk(clk), .rst_n(rst_n), .tx_go(tx_go && sel), .dst_ip(dst_ip),
        .protocol(protocol), .payload_len(payload_len), .busy(busy_b), .len_err(len_err_b),
        .mac_go(mac_go_b), .mac_len(mac_len_b), .mac_rq(mac_rq && sel), .mac_data(mac_data_b),
        .fifo_rq(fifo_rq_b), .fifo_da(fifo_da), .tx_done(tx_done_b)
    );

    assign busy     = sel ? busy_b     : busy_a;
    assign len_err  = sel ? len_err_b  : len_err_a;
    assign mac_go   = sel ? mac_go_b   : mac_go_a;
    assign fifo_rq  = sel ? fifo_rq_b  : fifo_rq_a;
    assign tx_done  = sel ? tx_done_b  : tx_done_a;
    assign mac_len  = sel ? mac_len_b  : mac_len_a;
    assign mac_data = sel ? mac_data_b : mac_data_a;

    // Show-ahead payload FIFO model
    logic [3:0]  pay_mem [0:4095];
    int          fifo_pops = 0;
    int          pop_base  = 0;
    logic [11:0] fifo_idx;
    always @(posedge clk) if (fifo_rq) fifo_pops <= fifo_pops + 1;
    assign fifo_idx = 12'(fifo_pops - pop_base);
    assign fifo_da  = pay_mem[fifo_idx];

    logic [3:0]  exp_nib [0:4095];
    logic [3:0]  got_nib [0:4095];
    int          got_cnt;
    logic [15:0] exp_id [0:1];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: header as bytes, ones-complement sum with end-around carry, then nibbles.
    task automatic build_expected(input logic [15:0] id, input logic [31:0] dst,
                                  input logic [7:0] proto, input int len, output int total);
        logic [7:0]  h [0:19];
        logic [15:0] tl, cs, fl;
        logic [31:0] src;
        int          sum;
        tl  = 16'(20 + len);
        fl  = FLAGS_EXP;
        src = SRC;
        h[0] = 8'h45;     h[1] = 8'h00;     h[2] = tl[15:8];  h[3] = tl[7:0];
        h[4] = id[15:8];  h[5] = id[7:0];   h[6] = fl[15:8];  h[7] = fl[7:0];
        h[8] = TTL_V;     h[9] = proto;     h[10] = 8'h00;    h[11] = 8'h00;
        for (int b = 0; b < 4; b++) begin
            h[12+b] = src[31-8*b -: 8];
            h[16+b] = dst[31-8*b -: 8];
        end
        sum = 0;
        for (int k = 0; k < 10; k++) sum += int'({h[2*k], h[2*k+1]});
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >>> 16);
        cs = ~16'(sum);
        h[10] = cs[15:8];
        h[11] = cs[7:0];
        for (int b = 0; b < 20; b++) begin
            exp_nib[2*b]   = h[b][3:0];
            exp_nib[2*b+1] = h[b][7:4];
        end
        for (int p = 0; p < 2*len; p++) exp_nib[40+p] = pay_mem[p];
        total = 40 + 2*len;
    endtask

    task automatic run_packet(input logic [31:0] dst, input logic [7:0] proto, input int len,
                              input int gap, input int abort_at);
        int   total, inst, exp_pops;
        logic aborted;
        inst    = sel ? 1 : 0;
        aborted = 1'b0;
        for (int p = 0; p < 2*len; p++) pay_mem[p] = 4'($urandom);
        pop_base = fifo_pops;
        build_expected(exp_id[inst], dst, proto, len, total);
        got_cnt = 0;
        @(negedge clk);
        dst_ip = dst; protocol = proto; payload_len = 11'(len); tx_go = 1'b1;
        @(negedge clk);
        tx_go = 1'b0;
        check_eq("busy_calc", 32'(busy), 1);
        check_eq("mac_len", 32'(mac_len), 32'(20 + len));
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 3) begin tx_go = 1'b1; payload_len = 11'd0; end
            else tx_go = 1'b0;
            check_eq("mac_go", 32'(mac_go), 32'(k == 11));
            check_eq("len_err_busy", 32'(len_err), 0);
        end
        @(negedge clk);
        repeat (gap) begin
            check_eq("wait_data", 32'(mac_data), 0);
            @(negedge clk);
        end
        for (int i = 0; i < total; i++) begin
            if (i == abort_at) begin
                mac_rq = 1'b0; #1;
                check_eq("abort_fifo_rq", 32'(fifo_rq), 0);
                @(negedge clk);
                check_eq("abort_busy", 32'(busy), 0);
                check_eq("abort_done", 32'(tx_done), 0);
                check_eq("abort_data", 32'(mac_data), 0);
                aborted = 1'b1;
                break;
            end
            mac_rq = 1'b1; #1;
            check_eq("fifo_rq", 32'(fifo_rq), 32'(i >= 40));
            @(negedge clk);
            check_eq("nibble", 32'(mac_data), 32'(exp_nib[i]));
            got_nib[i] = mac_data;
            got_cnt++;
            if (i == total - 1) begin
                mac_rq = 1'b0;
                check_eq("tx_done", 32'(tx_done), 1);
                check_eq("busy_end", 32'(busy), 0);
            end else begin
                check_eq("tx_done_early", 32'(tx_done), 0);
                check_eq("busy_stream", 32'(busy), 1);
            end
        end
        mac_rq = 1'b0;
        if (aborted) exp_pops = (abort_at > 40) ? abort_at - 40 : 0;
        else begin
            @(negedge clk);
            check_eq("tx_done_once", 32'(tx_done), 0);
            check_eq("idle_data", 32'(mac_data), 0);
            exp_id[inst] = exp_id[inst] + 16'd1;
            exp_pops = 2*len;
        end
        check_eq("fifo_pops", 32'(fifo_pops - pop_base), 32'(exp_pops));
        $display("packet inst=%0d dst=%h proto=%0d len=%0d gap=%0d abort=%0d nibbles=%0d",
                 inst, dst, proto, len, gap, abort_at, got_cnt);
    endtask

    task automatic reject(input int len);
        @(negedge clk);
        payload_len = 11'(len); tx_go = 1'b1;
        @(negedge clk);
        tx_go = 1'b0;
        check_eq("len_err", 32'(len_err), 1);
        check_eq("rej_busy", 32'(busy), 0);
        @(negedge clk);
        check_eq("len_err_pulse", 32'(len_err), 0);
        check_eq("rej_busy2", 32'(busy), 0);
        check_eq("rej_mac_go", 32'(mac_go), 0);
        $display("reject len=%0d", len);
    endtask

    initial begin
        #(40 * 80000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, tot;
        rst_n = 1'b0; tx_go = 1'b0; mac_rq = 1'b0; sel = 1'b0;
        dst_ip = '0; protocol = '0; payload_len = '0;
        exp_id[0] = 16'h0000;
        exp_id[1] = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_len_err", 32'(len_err), 0);
        check_eq("rst_mac_go", 32'(mac_go), 0);
        check_eq("rst_mac_len", 32'(mac_len), 0);
        check_eq("rst_mac_data", 32'(mac_data), 0);
        check_eq("rst_fifo_rq", 32'(fifo_rq), 0);
        check_eq("rst_tx_done", 32'(tx_done), 0);
        rst_n = 1'b1;

        run_packet(32'hC0A8_8901, 8'd17, 8, 2, -1);
        check_eq("nom_csum", {16'h0, got_nib[21], got_nib[20], got_nib[23], got_nib[22]}, 32'(NOM_CSUM));
        check_eq("nom_first", {16'h0, got_nib[3], got_nib[2], got_nib[1], got_nib[0]}, 32'h0045);
        check_eq("nom_flags", {16'h0, got_nib[15], got_nib[14], got_nib[13], got_nib[12]}, 32'(NOM_FLNIB));
        check_eq("nom_count", 32'(got_cnt), 56);

        reject(0);
        reject(1481);

        run_packet(32'h0A00_0001, 8'd6, 20, 0, 45);
        run_packet(32'h0A00_0001, 8'd6, 20, 1, -1);
        run_packet($urandom, 8'($urandom), 1, 0, -1);
        run_packet($urandom, 8'($urandom), 1480, 3, -1);
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 64);
            tot = 40 + 2*len;
            run_packet($urandom, 8'($urandom), len, $urandom_range(0, 4),
                       ($urandom_range(0, 2) == 0) ? $urandom_range(1, tot - 1) : -1);
        end

        sel = 1'b1;
        run_packet(32'hC0A8_8901, 8'd17, 8, 0, -1);
        run_packet(32'hC0A8_8901, 8'd17, 8, 0, -1);
        check_eq("wrap_id", {16'h0, got_nib[9], got_nib[8], got_nib[11], got_nib[10]}, 0);
        sel = 1'b0;

        @(negedge clk);
        dst_ip = 32'h0102_0304; protocol = 8'd1; payload_len = 11'd10; tx_go = 1'b1;
        @(negedge clk);
        tx_go = 1'b0;
        repeat (11) @(negedge clk);
        mac_rq = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("mid_busy_pre", 32'(busy), 1);
        rst_n = 1'b0; #1;
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_data", 32'(mac_data), 0);
        check_eq("mid_rst_fifo_rq", 32'(fifo_rq), 0);
        check_eq("mid_rst_mac_len", 32'(mac_len), 0);
        mac_rq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_id[0] = 16'h0000;
        exp_id[1] = 16'hFFFF;
        $display("reset mid-packet");
        run_packet($urandom, 8'd17, 5, 1, -1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
